// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Purpose : shared definitions for the program-counter stage.
//   - pc_state_t       : FSM states (S_INIT, S_RUN, S_HALT)
//   - WORD_BYTES       : instruction word size in bytes
//   - DEFAULT_RESET_PC : default PC loaded on reset
// ---------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } pc_state_t;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : pc_pkg

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Purpose : purely combinational next-PC generation. Builds the sequential,
//           branch and jump candidate targets from the current PC, selects
//           one by redirect priority (jr > jump > branch > sequential) and
//           flags whether the selected address is misaligned or outside the
//           instruction memory.
// Ports   :
//   i_pc           current PC
//   i_branch       taken branch, offset in i_branch_imm (words, signed)
//   i_jump         J/JAL, word index in i_jump_target
//   i_jr           register-indirect jump to i_jr_addr
//   o_seq_target   PC+4 (also the JAL link value)
//   o_next_pc      selected next PC
//   o_fault        selected next PC is misaligned or out of range
// ---------------------------------------------------------------------------
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic [31:0] i_pc,
  input  logic        i_branch,
  input  logic [15:0] i_branch_imm,
  input  logic        i_jump,
  input  logic [25:0] i_jump_target,
  input  logic        i_jr,
  input  logic [31:0] i_jr_addr,
  output logic [31:0] o_seq_target,
  output logic [31:0] o_next_pc,
  output logic        o_fault
);

  // Highest legal fetch address.
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - WORD_BYTES);

  logic [31:0] w_seq_target;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_offset;
  logic [31:0] w_next_pc;

  // Carries out of bit 31 are simply dropped by the 32-bit adders; a
  // wrapped result lands wherever it lands and is then range-checked.
  assign w_seq_target    = i_pc + 32'(WORD_BYTES);
  assign w_branch_offset = {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};
  assign w_branch_target = w_seq_target + w_branch_offset;
  // Jump keeps the 256 MB region of the instruction after the current one.
  assign w_jump_target   = {w_seq_target[31:28], i_jump_target, 2'b00};

  always_comb begin
    w_next_pc = w_seq_target;
    if (i_jr) begin
      w_next_pc = i_jr_addr;
    end else if (i_jump) begin
      w_next_pc = w_jump_target;
    end else if (i_branch) begin
      w_next_pc = w_branch_target;
    end
  end

  assign o_seq_target = w_seq_target;
  assign o_next_pc    = w_next_pc;
  assign o_fault      = (w_next_pc[1:0] != 2'b00) || (w_next_pc > LAST_PC);

endmodule : pc_target_calc

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Purpose : program-counter stage feeding the instruction memory. Holds the
//           registered fetch address, advances or redirects it each cycle,
//           and stops permanently (until reset) on halt or on a bad target.
// Ports   :
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_stall          hold PC this cycle (redirects are dropped)
//   i_branch/_imm    taken branch, signed word offset
//   i_jump/_target   J/JAL, 26-bit word index
//   i_jr/_addr       register-indirect jump, byte address
//   i_halt_req       stop fetching
//   o_pc             current fetch address
//   o_pc_plus4       o_pc + 4, combinational
//   o_pc_valid       o_pc is a live fetch address (S_RUN)
//   o_fault          sticky misaligned/out-of-range flag
//   o_halted         in S_HALT
//   o_fetch_count    PC advances since reset
// ---------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch,
  input  logic [15:0] i_branch_imm,
  input  logic        i_jump,
  input  logic [25:0] i_jump_target,
  input  logic        i_jr,
  input  logic [31:0] i_jr_addr,
  input  logic        i_halt_req,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_pc_valid,
  output logic        o_fault,
  output logic        o_halted,
  output logic [31:0] o_fetch_count
);

  pc_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic        r_fault;

  pc_state_t   w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_fetch_count_next;
  logic        w_fault_next;

  logic [31:0] w_seq_target;
  logic [31:0] w_calc_next_pc;
  logic        w_calc_fault;

  pc_target_calc #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_target_calc (
    .i_pc          (r_pc),
    .i_branch      (i_branch),
    .i_branch_imm  (i_branch_imm),
    .i_jump        (i_jump),
    .i_jump_target (i_jump_target),
    .i_jr          (i_jr),
    .i_jr_addr     (i_jr_addr),
    .o_seq_target  (w_seq_target),
    .o_next_pc     (w_calc_next_pc),
    .o_fault       (w_calc_fault)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_INIT;
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'd0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_fetch_count <= w_fetch_count_next;
      r_fault       <= w_fault_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_fetch_count_next = r_fetch_count;
    w_fault_next       = r_fault;
    case (r_state)
      // One idle cycle so the memory can present the word at RESET_PC
      // before decode starts acting on it; control inputs are ignored.
      S_INIT: begin
        w_state_next = S_RUN;
        w_pc_next    = RESET_PC;
      end
      S_RUN: begin
        if (i_halt_req) begin
          w_state_next = S_HALT;
        end else if (i_stall) begin
          // Hold; any redirect this cycle is dropped and must be re-presented.
          w_pc_next = r_pc;
        end else if (w_calc_fault) begin
          // Bad target: keep the last good PC and stop on this same edge.
          w_fault_next = 1'b1;
          w_state_next = S_HALT;
        end else begin
          w_pc_next          = w_calc_next_pc;
          w_fetch_count_next = r_fetch_count + 32'd1;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_INIT;
      end
    endcase
  end

  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_seq_target;
  assign o_pc_valid    = (r_state == S_RUN);
  assign o_halted      = (r_state == S_HALT);
  assign o_fault       = r_fault;
  assign o_fetch_count = r_fetch_count;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (IMEM_BYTES = 256, RESET_PC = 0).
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        fault;
  logic        halted;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (256)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_stall       (stall),
    .i_branch      (branch),
    .i_branch_imm  (branch_imm),
    .i_jump        (jump),
    .i_jump_target (jump_target),
    .i_jr          (jr),
    .i_jr_addr     (jr_addr),
    .i_halt_req    (halt_req),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4),
    .o_pc_valid    (pc_valid),
    .o_fault       (fault),
    .o_halted      (halted),
    .o_fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] bimm;
    logic        jmp;
    logic [25:0] jtgt;
    logic        jr;
    logic [31:0] jaddr;
    logic        halt;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_fault;
    logic        exp_halted;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(
    input logic rst, input logic stl, input logic br, input logic [15:0] bimm,
    input logic jmp, input logic [25:0] jtgt, input logic jrv, input logic [31:0] jaddr,
    input logic hlt, input logic [31:0] e_pc, input logic e_valid,
    input logic e_fault, input logic e_halted, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stall = stl; v.br = br; v.bimm = bimm;
    v.jmp = jmp; v.jtgt = jtgt; v.jr = jrv; v.jaddr = jaddr; v.halt = hlt;
    v.exp_pc = e_pc; v.exp_valid = e_valid; v.exp_fault = e_fault;
    v.exp_halted = e_halted; v.exp_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; stall = 1'b0; branch = 1'b0; branch_imm = 16'h0;
    jump = 1'b0; jump_target = 26'h0; jr = 1'b0; jr_addr = 32'h0; halt_req = 1'b0;
  endtask

  // Apply one set of inputs, clock once, check all outputs 1 time unit later.
  task automatic step(input string tag, input vec_t v);
    reset = v.rst; stall = v.stall; branch = v.br; branch_imm = v.bimm;
    jump = v.jmp; jump_target = v.jtgt; jr = v.jr; jr_addr = v.jaddr; halt_req = v.halt;
    @(posedge clk);
    #1;
    $display("%s: pc=%h plus4=%h valid=%0b fault=%0b halted=%0b cnt=%0d",
             tag, pc, pc_plus4, pc_valid, fault, halted, fetch_count);
    chk({tag, " pc"},       pc,                 v.exp_pc);
    chk({tag, " pc_plus4"}, pc_plus4,           v.exp_pc + 32'd4);
    chk({tag, " pc_valid"}, {31'd0, pc_valid},  {31'd0, v.exp_valid});
    chk({tag, " fault"},    {31'd0, fault},     {31'd0, v.exp_fault});
    chk({tag, " halted"},   {31'd0, halted},    {31'd0, v.exp_halted});
    chk({tag, " count"},    fetch_count,        v.exp_cnt);
  endtask

  task automatic seq_step(input string tag, input logic rst, input logic stl,
                          input logic jrv, input logic [31:0] jaddr, input logic hlt,
                          input logic [31:0] e_pc, input logic e_valid, input logic e_fault,
                          input logic e_halted, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stall = stl; v.br = 1'b0; v.bimm = 16'h0;
    v.jmp = hlt; v.jtgt = 26'd10; // a jump alongside halt must be ignored
    v.jr = jrv; v.jaddr = jaddr; v.halt = hlt;
    v.exp_pc = e_pc; v.exp_valid = e_valid; v.exp_fault = e_fault;
    v.exp_halted = e_halted; v.exp_cnt = e_cnt;
    step(tag, v);
  endtask

  initial begin
    drive_idle();

    //        rst stl br  bimm      jmp jtgt    jr  jaddr          hlt  pc      v  f  h  cnt
    add_vec(1'b0,1'b0,1'b0,16'h0000,1'b0,26'd0, 1'b0,32'h0,        1'b0,32'd0,  1,0,0,32'd0); // S_INIT -> S_RUN
    add_vec(1'b0,1'b0,1'b0,16'h0000,1'b0,26'd0, 1'b0,32'h0,        1'b0,32'd4,  1,0,0,32'd1);
    add_vec(1'b0,1'b0,1'b0,16'h0000,1'b0,26'd0, 1'b0,32'h0,        1'b0,32'd8,  1,0,0,32'd2);
    add_vec(1'b0,1'b0,1'b1,16'hFFFE,1'b0,26'd0, 1'b0,32'h0,        1'b0,32'd4,  1,0,0,32'd3); // 12-8
    add_vec(1'b0,1'b0,1'b1,16'h0003,1'b0,26'd0, 1'b0,32'h0,        1'b0,32'd20, 1,0,0,32'd4); // 8+12
    add_vec(1'b0,1'b1,1'b0,16'h0000,1'b1,26'd10,1'b0,32'h0,        1'b0,32'd20, 1,0,0,32'd4); // stall drops jump
    add_vec(1'b0,1'b0,1'b0,16'h0000,1'b1,26'd10,1'b0,32'h0,        1'b0,32'd40, 1,0,0,32'd5);
    add_vec(1'b0,1'b0,1'b0,16'h0000,1'b0,26'd0, 1'b1,32'h30,       1'b0,32'd48, 1,0,0,32'd6);
    add_vec(1'b0,1'b0,1'b1,16'h0001,1'b1,26'd10,1'b1,32'h10,       1'b0,32'd16, 1,0,0,32'd7); // jr wins
    add_vec(1'b0,1'b0,1'b1,16'h0005,1'b1,26'd3, 1'b0,32'h0,        1'b0,32'd12, 1,0,0,32'd8); // jump wins
    add_vec(1'b0,1'b0,1'b1,16'h0002,1'b0,26'd0, 1'b0,32'h0,        1'b0,32'd24, 1,0,0,32'd9); // 16+8
    add_vec(1'b0,1'b0,1'b0,16'h0000,1'b0,26'd0, 1'b1,32'h6,        1'b0,32'd24, 0,1,1,32'd9); // misaligned
    add_vec(1'b0,1'b0,1'b0,16'h0000,1'b0,26'd0, 1'b1,32'h40,       1'b0,32'd24, 0,1,1,32'd9); // ignored in halt
    add_vec(1'b1,1'b0,1'b0,16'h0000,1'b0,26'd0, 1'b1,32'h40,       1'b0,32'd0,  0,0,0,32'd0); // reset from halt
    add_vec(1'b0,1'b0,1'b0,16'h0000,1'b1,26'd10,1'b0,32'h0,        1'b0,32'd0,  1,0,0,32'd0); // S_INIT ignores jump

    // Reset values after the reset edge.
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("reset: pc=%h plus4=%h valid=%0b fault=%0b halted=%0b cnt=%0d",
             pc, pc_plus4, pc_valid, fault, halted, fetch_count);
    chk("reset pc",       pc,                32'd0);
    chk("reset pc_plus4", pc_plus4,          32'd4);
    chk("reset pc_valid", {31'd0, pc_valid}, 32'd0);
    chk("reset fault",    {31'd0, fault},    32'd0);
    chk("reset halted",   {31'd0, halted},   32'd0);
    chk("reset count",    fetch_count,       32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Sequential fall-off from the last word: no wrap, fault and hold.
    //       tag        rst  stl  jr   jaddr    hlt   pc       v  f  h  cnt
    seq_step("fall0", 1'b0,1'b0,1'b1,32'd248,1'b0, 32'd248, 1,0,0,32'd1);
    seq_step("fall1", 1'b0,1'b0,1'b0,32'd0,  1'b0, 32'd252, 1,0,0,32'd2);
    seq_step("fall2", 1'b0,1'b0,1'b0,32'd0,  1'b0, 32'd252, 0,1,1,32'd2);
    seq_step("fall3", 1'b1,1'b0,1'b0,32'd0,  1'b0, 32'd0,   0,0,0,32'd0);

    // halt_req beats stall (and a concurrent jump): clean halt, no fault.
    seq_step("halt0", 1'b0,1'b0,1'b0,32'd0,  1'b0, 32'd0,   1,0,0,32'd0);
    seq_step("halt1", 1'b0,1'b1,1'b0,32'd0,  1'b1, 32'd0,   0,0,1,32'd0);
    seq_step("halt2", 1'b0,1'b0,1'b0,32'd0,  1'b0, 32'd0,   0,0,1,32'd0);
    seq_step("halt3", 1'b1,1'b0,1'b0,32'd0,  1'b0, 32'd0,   0,0,0,32'd0);

    // Aligned but just past the end of memory.
    seq_step("oor0",  1'b0,1'b0,1'b0,32'd0,  1'b0, 32'd0,   1,0,0,32'd0);
    seq_step("oor1",  1'b0,1'b0,1'b1,32'd256,1'b0, 32'd0,   0,1,1,32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_unit
